nn_img_rd: RTL
==============

// Module: nn_img_rd
// PURPOSE
//  Read-side controller for the synchronous-write / combinational-read image buffer.
//  Walks a rectangular window (rows x words, with row stride) and issues one buffer address per cycle.
//  Streams the read words to the PE array over a valid/ready interface, one word per beat.
//  Sits between the image buffer read port and the PE input. Full throughput: 1 beat/cycle under no backpressure.
// PARAMETERS
//  DATA_WIDTH        8                 bits per pixel
//  ADDR_WIDTH        10                buffer address width
//  TOTAL_DATA_WIDTH  DATA_WIDTH*6      buffer word width (6 pixels per word)
// PORTS
//  i_clk         in   1                 clock, rising edge
//  i_rst         in   1                 synchronous reset, active-high
//  i_start       in   1                 start job; sampled only in IDLE
//  i_base_addr   in   ADDR_WIDTH        address of word 0 of row 0
//  i_row_len     in   ADDR_WIDTH        words per row; 0 = empty job
//  i_row_cnt     in   ADDR_WIDTH        rows per job; 0 = empty job
//  i_row_stride  in   ADDR_WIDTH        address step between row starts
//  o_busy        out  1                 job in progress (RUN or DRAIN)
//  o_done        out  1                 1-cycle pulse at job end
//  o_rd_en       out  1                 buffer read strobe
//  o_rd_addr     out  ADDR_WIDTH        buffer read address
//  i_rd_data     in   TOTAL_DATA_WIDTH  buffer read data, valid same cycle as o_rd_addr
//  o_data        out  TOTAL_DATA_WIDTH  stream data
//  o_valid       out  1                 stream valid
//  i_ready       in   1                 stream ready from PE
//  o_last        out  1                 marks the final beat of the job
//  o_stall_cnt   out  32                backpressure cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters, o_data and o_stall_cnt cleared. i_rst mid-job aborts immediately.
//    No o_done pulse; any pending o_valid dropped.
//  - Job parameters are latched at start; input changes during a job have no effect.
//  - FSM: IDLE -> RUN when i_start and both lengths != 0.
//    IDLE -> DONE when i_start and either length == 0 (no beats issued).
//    RUN -> DRAIN after the final address is issued.
//    DRAIN -> DONE when the final beat handshakes (o_valid & i_ready).
//    DONE -> IDLE unconditionally. o_done = 1 only in DONE.
//  - i_start ignored outside IDLE.
//  - o_busy = (state==RUN)|(state==DRAIN).
//  - Issue rule: o_rd_en = (state==RUN) & (!o_valid | i_ready).
//    o_rd_addr = row_base + col, mod 2^ADDR_WIDTH (wrap-around allowed, no error).
//  - Counter update on issue:
//    - col++ ; at col==row_len-1: col=0, row++, row_base += i_row_stride (mod 2^ADDR_WIDTH).
//    - Final address: row==row_cnt-1 and col==row_len-1.
//  - Output register load: on o_rd_en, o_data <= i_rd_data, o_valid <= 1, o_last <= (final address).
//  - Handshake: o_valid & i_ready with no new issue clears o_valid and o_last.
//    o_data/o_last held stable while o_valid & !i_ready.
//  - Latency: i_start at cycle T (IDLE) -> first o_rd_en at T+1 -> first o_valid at T+2.
//    Last handshake at cycle L -> o_done at L+1. Next i_start accepted at L+2.
//  - Job of N=row_len*row_cnt words with i_ready stuck 1: exactly N beats on consecutive cycles.
// CONFIGURATION
//  - NN_IMG_RD_PERF_EN defined: o_stall_cnt counts cycles with o_valid & !i_ready.
//    Cleared when a job starts; holds its value after o_done until the next start. Saturates at 2^32-1.
//  - Not defined: o_stall_cnt tied to 0; no counter logic is synthesised.
// TESTING
//  - Basic: base=0x010, len=4, cnt=3, stride=8, i_ready=1 -> addrs 10..13, 18..1B, 20..23.
//    12 beats back-to-back; o_last on beat 12 only; o_done one cycle after.
//  - Backpressure: same job, i_ready toggling 1,0,0,1...
//    -> o_data stable while stalled; no beat lost or duplicated; o_rd_en low while o_valid & !i_ready.
//    With NN_IMG_RD_PERF_EN: o_stall_cnt equals the stalled-cycle count.
//  - Wrap: base=0x3FE, len=4, cnt=1 -> addrs 3FE, 3FF, 000, 001.
//  - Empty job: len=0 (and separately cnt=0) -> no o_rd_en, no o_valid; o_done pulses at T+1.
//  - Start while busy: i_start pulsed mid-job -> ignored; job completes normally with one o_done.
//  - Reset mid-job: i_rst after beat 5 of 12 -> next cycle all outputs 0, state IDLE.
//    A fresh job then runs correctly from word 0.

Source files
------------

// File: rtl/nn_img_rd_if.sv
// -----------------------------------------------------------------------------
// nn_img_rd_if
// Bundles the two buses of the image-buffer read controller:
//   - buffer read port : rd_en / rd_addr out, rd_data back (combinational read)
//   - PE stream        : data / valid / last out, ready back
// Modports:
//   master : the read controller (drives strobe, address and stream)
//   slave  : the environment (image buffer + PE input)
// -----------------------------------------------------------------------------
interface nn_img_rd_if #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 10,
    parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * 6
);
    logic                        rd_en;
    logic [ADDR_WIDTH-1:0]       rd_addr;
    logic [TOTAL_DATA_WIDTH-1:0] rd_data;
    logic [TOTAL_DATA_WIDTH-1:0] data;
    logic                        valid;
    logic                        ready;
    logic                        last;

    modport master (
        output rd_en, rd_addr, data, valid, last,
        input  rd_data, ready
    );

    modport slave (
        input  rd_en, rd_addr, data, valid, last,
        output rd_data, ready
    );
endinterface

// File: rtl/nn_img_rd.sv
// -----------------------------------------------------------------------------
// nn_img_rd
// Read-side controller for the image buffer. Walks a rows x words window with a
// row stride, issues one buffer address per cycle and streams the returned
// words to the PE array, one word per beat, at full throughput.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_start             start a job (only looked at in IDLE)
//   i_base_addr         address of word 0 of row 0
//   i_row_len/_cnt      window size; either one 0 means an empty job
//   i_row_stride        address step between row starts
//   o_busy              job in progress
//   o_done              one-cycle pulse at job end
//   o_stall_cnt         backpressure cycle count (0 unless NN_IMG_RD_PERF_EN)
//   bus (master)        buffer read port + PE stream
//
// Optional feature macro: NN_IMG_RD_PERF_EN enables the stall counter.
// -----------------------------------------------------------------------------
module nn_img_rd #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 10,
    parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_row_len,
    input  logic [ADDR_WIDTH-1:0] i_row_cnt,
    input  logic [ADDR_WIDTH-1:0] i_row_stride,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [31:0]           o_stall_cnt,
    nn_img_rd_if.master           bus
);

    localparam logic [ADDR_WIDTH-1:0] A_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                      state_r;
    logic [ADDR_WIDTH-1:0]       len_r;
    logic [ADDR_WIDTH-1:0]       cnt_r;
    logic [ADDR_WIDTH-1:0]       stride_r;
    logic [ADDR_WIDTH-1:0]       row_base_r;
    logic [ADDR_WIDTH-1:0]       col_r;
    logic [ADDR_WIDTH-1:0]       row_r;
    logic                        busy_r;
    logic                        done_r;
    logic [TOTAL_DATA_WIDTH-1:0] data_r;
    logic                        valid_r;
    logic                        last_r;

    logic                        issue_s;
    logic                        col_end_s;
    logic                        final_s;

    // Issue decision and window-position decode. A new word may be issued
    // whenever the output register is empty or is being drained this cycle.
    always_comb begin
        issue_s   = (state_r == ST_RUN) && (!valid_r || bus.ready);
        col_end_s = (col_r == (len_r - A_ONE));
        final_s   = col_end_s && (row_r == (cnt_r - A_ONE));
    end

    assign bus.rd_en   = issue_s;
    assign bus.rd_addr = row_base_r + col_r;   // wraps modulo 2^ADDR_WIDTH
    assign bus.data    = data_r;
    assign bus.valid   = valid_r;
    assign bus.last    = last_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;

    // Job FSM: latches job parameters, walks the window, registers busy/done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            len_r      <= A_ZERO;
            cnt_r      <= A_ZERO;
            stride_r   <= A_ZERO;
            row_base_r <= A_ZERO;
            col_r      <= A_ZERO;
            row_r      <= A_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        len_r      <= i_row_len;
                        cnt_r      <= i_row_cnt;
                        stride_r   <= i_row_stride;
                        row_base_r <= i_base_addr;
                        col_r      <= A_ZERO;
                        row_r      <= A_ZERO;
                        if ((i_row_len != A_ZERO) && (i_row_cnt != A_ZERO)) begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                        end else begin
                            // Empty job: nothing to read, report completion directly.
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        if (col_end_s) begin
                            col_r      <= A_ZERO;
                            row_r      <= row_r + A_ONE;
                            row_base_r <= row_base_r + stride_r;
                        end else begin
                            col_r <= col_r + A_ONE;
                        end
                        if (final_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Only the final word can be pending here.
                    if (valid_r && bus.ready && last_r) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stream output register: loads on issue, empties on a handshake without
    // refill, and holds data/last while the PE stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_r  <= {TOTAL_DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (issue_s) begin
            data_r  <= bus.rd_data;
            valid_r <= 1'b1;
            last_r  <= final_s;
        end else if (valid_r && bus.ready) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

`ifdef NN_IMG_RD_PERF_EN
    logic [31:0] stall_cnt_r;

    // Stall counter: cleared when a job is accepted, saturating count of
    // cycles where a word waits on the PE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && i_start) begin
            stall_cnt_r <= 32'd0;
        end else if (valid_r && !bus.ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign o_stall_cnt = stall_cnt_r;
`else
    assign o_stall_cnt = 32'd0;
`endif

endmodule
